// File: rtl/seg_scan.sv
// Eight-digit multiplexed 7-segment scanner with frame-synchronous display update and guard blanking.
// seg and num are registered and change on the same edge; load is always accepted (no backpressure).
module seg_scan #(
    parameter int DIV_CNT = 50000,
    parameter int GUARD   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    output logic [2:0]  num,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int CW = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV_CNT - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    num_q, num_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic [7:0]    pend_dp_q, pend_dp_d;
    logic [7:0]    pend_en_q, pend_en_d;
    logic [31:0]   disp_data_q, disp_data_d;
    logic [7:0]    disp_dp_q, disp_dp_d;
    logic [7:0]    disp_en_q, disp_en_d;

    logic          tick;
    logic          boundary;
    logic [3:0]    digit;
    logic [7:0]    pat;

    function automatic logic [7:0] hex_pat(input logic [3:0] h);
        case (h)
            4'h0: hex_pat = 8'hC0;
            4'h1: hex_pat = 8'hF9;
            4'h2: hex_pat = 8'hA4;
            4'h3: hex_pat = 8'hB0;
            4'h4: hex_pat = 8'h99;
            4'h5: hex_pat = 8'h92;
            4'h6: hex_pat = 8'h82;
            4'h7: hex_pat = 8'hF8;
            4'h8: hex_pat = 8'h80;
            4'h9: hex_pat = 8'h90;
            4'hA: hex_pat = 8'h88;
            4'hB: hex_pat = 8'h83;
            4'hC: hex_pat = 8'hC6;
            4'hD: hex_pat = 8'hA1;
            4'hE: hex_pat = 8'h86;
            default: hex_pat = 8'h8E;
        endcase
    endfunction

    always_comb begin
        tick         = (cnt_q == CNT_MAX);
        boundary     = tick && (num_q == 3'd7);
        cnt_d        = tick ? '0 : cnt_q + CW'(1);
        num_d        = tick ? num_q + 3'd1 : num_q;
        frame_done_d = boundary;

        pend_data_d  = load ? data_in : pend_data_q;
        pend_dp_d    = load ? dp_in   : pend_dp_q;
        pend_en_d    = load ? en_in   : pend_en_q;

        // Copying from pend_*_d lets a load on the boundary edge reach the display without a frame of delay.
        disp_data_d  = boundary ? pend_data_d : disp_data_q;
        disp_dp_d    = boundary ? pend_dp_d   : disp_dp_q;
        disp_en_d    = boundary ? pend_en_d   : disp_en_q;

        digit        = disp_data_d[{num_d, 2'b00} +: 4];
        pat          = hex_pat(digit);
        seg_d        = 8'hFF;
        if ((cnt_d >= GUARD_C) && disp_en_d[num_d]) begin
            seg_d = {~disp_dp_d[num_d], pat[6:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            num_q        <= 3'd0;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
            pend_data_q  <= 32'd0;
            pend_dp_q    <= 8'd0;
            pend_en_q    <= 8'd0;
            disp_data_q  <= 32'd0;
            disp_dp_q    <= 8'd0;
            disp_en_q    <= 8'd0;
        end else begin
            cnt_q        <= cnt_d;
            num_q        <= num_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            disp_en_q    <= disp_en_d;
        end
    end

    assign num        = num_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule
